// File: rtl/io_loader_pkg.sv
// Shared types and widths for the input-device load sequencer.
package io_loader_pkg;

  localparam int unsigned ADDR_W            = 12;
  localparam int unsigned WORD_W            = 31;
  localparam int unsigned DATA_W            = 30;
  localparam int unsigned DEF_REPLY_TIMEOUT = 15;

  typedef enum logic [2:0] {
    StIdle,
    StWaitWord,
    StReq,
    StWaitReply,
    StDone
  } state_e;

endpackage

// File: rtl/io_loader_if.sv
// Device word handshake plus memory write request/reply bus.
interface io_loader_if
  import io_loader_pkg::*;
();

  logic              in_valid_from_dev;
  logic [WORD_W-1:0] in_word_from_dev;
  logic              in_ready_to_dev;
  logic              mem_write_from_io;
  logic              mem_write_reply_to_io;
  logic [ADDR_W-1:0] addr_to_sel;
  logic              write_sign_to_ac;
  logic [DATA_W-1:0] write_data_to_au;

  // Loader side.
  modport master (
    input  in_valid_from_dev,
    input  in_word_from_dev,
    output in_ready_to_dev,
    output mem_write_from_io,
    input  mem_write_reply_to_io,
    output addr_to_sel,
    output write_sign_to_ac,
    output write_data_to_au
  );

  // Device and memory side.
  modport slave (
    output in_valid_from_dev,
    output in_word_from_dev,
    input  in_ready_to_dev,
    input  mem_write_from_io,
    output mem_write_reply_to_io,
    input  addr_to_sel,
    input  write_sign_to_ac,
    input  write_data_to_au
  );

endinterface

// File: rtl/io_reply_timer.sv
// Clear/enable cycle counter; flags expiry on the last allowed cycle of a reply wait.
module io_reply_timer #(
  parameter int unsigned TIMER_W       = 4,
  parameter int unsigned REPLY_TIMEOUT = 15
) (
  input  logic clk,
  input  logic resetn,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  logic [TIMER_W-1:0] r_count;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + 1'b1;
    end
  end

  // Counting starts in the request cycle, so value N means N cycles since the request.
  assign o_expired = i_enable && (r_count == TIMER_W'(REPLY_TIMEOUT - 1));

endmodule

// File: rtl/io_loader.sv
// Loads device words into memory at auto-incrementing addresses with checksum and timeout.
module io_loader
  import io_loader_pkg::*;
#(
  parameter int unsigned REPLY_TIMEOUT = DEF_REPLY_TIMEOUT,
  parameter int unsigned TIMER_W       = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start_from_pnl,
  input  logic              abort_from_pnl,
  input  logic [ADDR_W-1:0] start_addr_from_pnl,
  input  logic [ADDR_W-1:0] word_count_from_pnl,
  io_loader_if.master       bus,
  output logic              io_busy_to_pnl,
  output logic              io_done_to_pnl,
  output logic              io_error_to_pnl,
  output logic [WORD_W-1:0] checksum_to_pnl,
  output logic [ADDR_W-1:0] cur_addr_to_pnl
);

  state_e            r_state;
  logic              r_ready;
  logic              r_mem_write;
  logic              r_busy;
  logic              r_done;
  logic              r_error;
  logic              r_abort_pend;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [WORD_W-1:0] r_data;
  logic [WORD_W-1:0] r_checksum;
  logic [ADDR_W:0]   r_remaining;

  logic w_ready;
  logic w_accept;
  logic w_timer_en;
  logic w_expired;
  logic w_abort_any;

  assign w_ready     = r_ready & ~abort_from_pnl;
  assign w_accept    = w_ready & bus.in_valid_from_dev;
  assign w_timer_en  = (r_state == StReq) || (r_state == StWaitReply);
  assign w_abort_any = r_abort_pend | abort_from_pnl;

  io_reply_timer #(
    .TIMER_W      (TIMER_W),
    .REPLY_TIMEOUT(REPLY_TIMEOUT)
  ) u_timer (
    .clk      (clk),
    .resetn   (resetn),
    .i_clear  (w_accept),
    .i_enable (w_timer_en),
    .o_expired(w_expired)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= StIdle;
      r_ready      <= 1'b0;
      r_mem_write  <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_abort_pend <= 1'b0;
      r_addr       <= '0;
      r_mem_addr   <= '0;
      r_data       <= '0;
      r_checksum   <= '0;
      r_remaining  <= '0;
    end else begin
      r_mem_write <= 1'b0;
      r_done      <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (start_from_pnl && !abort_from_pnl) begin
            r_addr      <= start_addr_from_pnl;
            r_remaining <= (word_count_from_pnl == '0) ? {1'b1, {ADDR_W{1'b0}}}
                                                       : {1'b0, word_count_from_pnl};
            r_checksum  <= '0;
            r_error     <= 1'b0;
            r_busy      <= 1'b1;
            r_ready     <= 1'b1;
            r_state     <= StWaitWord;
          end
        end
        StWaitWord: begin
          if (abort_from_pnl) begin
            r_busy  <= 1'b0;
            r_ready <= 1'b0;
            r_state <= StIdle;
          end else if (w_accept) begin
            r_data      <= bus.in_word_from_dev;
            r_mem_addr  <= r_addr;
            r_ready     <= 1'b0;
            r_mem_write <= 1'b1;
            r_state     <= StReq;
          end
        end
        StReq: begin
          r_abort_pend <= w_abort_any;
          r_state      <= StWaitReply;
        end
        StWaitReply: begin
          // A reply in the expiry cycle still counts as a completed write.
          if (bus.mem_write_reply_to_io) begin
            r_checksum   <= r_checksum + r_data;
            r_addr       <= r_addr + 1'b1;
            r_remaining  <= r_remaining - 1'b1;
            r_abort_pend <= 1'b0;
            if (r_remaining == (ADDR_W + 1)'(1)) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= StDone;
            end else if (w_abort_any) begin
              r_busy  <= 1'b0;
              r_state <= StIdle;
            end else begin
              r_ready <= 1'b1;
              r_state <= StWaitWord;
            end
          end else if (w_expired) begin
            r_error      <= 1'b1;
            r_busy       <= 1'b0;
            r_abort_pend <= 1'b0;
            r_state      <= StIdle;
          end else begin
            r_abort_pend <= w_abort_any;
          end
        end
        StDone: begin
          r_state <= StIdle;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign bus.in_ready_to_dev   = w_ready;
  assign bus.mem_write_from_io = r_mem_write;
  assign bus.addr_to_sel       = r_mem_addr;
  assign bus.write_sign_to_ac  = r_data[WORD_W-1];
  assign bus.write_data_to_au  = r_data[DATA_W-1:0];

  assign io_busy_to_pnl  = r_busy;
  assign io_done_to_pnl  = r_done;
  assign io_error_to_pnl = r_error;
  assign checksum_to_pnl = r_checksum;
  assign cur_addr_to_pnl = r_addr;

endmodule

// File: tb/tb_io_loader.sv
// Directed bench for io_loader with a 2-cycle memory model and a gated device model.
module tb_io_loader;
  import io_loader_pkg::*;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [11:0] start_addr = '0;
  logic [11:0] word_count = '0;
  logic        busy, done, error;
  logic [30:0] checksum;
  logic [11:0] cur_addr;

  io_loader_if bus();

  io_loader #(.REPLY_TIMEOUT(15), .TIMER_W(4)) dut (
    .clk                (clk),
    .resetn             (resetn),
    .start_from_pnl     (start),
    .abort_from_pnl     (abort),
    .start_addr_from_pnl(start_addr),
    .word_count_from_pnl(word_count),
    .bus                (bus),
    .io_busy_to_pnl     (busy),
    .io_done_to_pnl     (done),
    .io_error_to_pnl    (error),
    .checksum_to_pnl    (checksum),
    .cur_addr_to_pnl    (cur_addr)
  );

  always #5 clk = ~clk;

  int          cyc = 0;
  bit          dev_on = 1'b0, dev_gap = 1'b0, mem_on = 1'b1, stray = 1'b0;
  logic [30:0] dev_words [8];
  int          acc_n = 0, wr_n = 0, done_n = 0;
  int          wr_cyc  [64];
  logic [11:0] wr_addr [64];
  logic        wr_sign [64];
  logic [29:0] wr_data [64];
  logic        mem_p0 = 1'b0, mem_reply = 1'b0;
  int          n_cmp = 0, n_bad = 0;

  assign bus.in_valid_from_dev     = dev_on && (!dev_gap || (cyc % 7 == 0));
  assign bus.in_word_from_dev      = dev_words[acc_n[2:0]];
  assign bus.mem_write_reply_to_io = mem_reply | stray;

  always @(posedge clk) begin
    cyc       <= cyc + 1;
    mem_p0    <= bus.mem_write_from_io && mem_on;
    mem_reply <= mem_p0;
    if (bus.in_valid_from_dev && bus.in_ready_to_dev) acc_n <= acc_n + 1;
    if (done) done_n <= done_n + 1;
    if (bus.mem_write_from_io) begin
      wr_cyc[wr_n[5:0]]  <= cyc;
      wr_addr[wr_n[5:0]] <= bus.addr_to_sel;
      wr_sign[wr_n[5:0]] <= bus.write_sign_to_ac;
      wr_data[wr_n[5:0]] <= bus.write_data_to_au;
      wr_n               <= wr_n + 1;
    end
  end

  function automatic logic [5:0] idx(input int i);
    return i[5:0];
  endfunction

  task automatic set_words(input logic [30:0] w0, w1, w2, fill);
    int a;
    for (int i = 0; i < 8; i++) begin
      a = acc_n + i;
      dev_words[a[2:0]] = (i == 0) ? w0 : (i == 1) ? w1 : (i == 2) ? w2 : fill;
    end
  endtask

  task automatic pulse_start(input logic [11:0] addr, input logic [11:0] cnt);
    start_addr = addr;
    word_count = cnt;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
  endtask

  task automatic wait_write(input int base, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (wr_n > base) seen = 1'b1;
    end
  endtask

  task automatic test_reset;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got %0h want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rst_done got %0h want 0", done); end
    n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL rst_err got %0h want 0", error); end
    n_cmp++; if (checksum !== 31'h0) begin n_bad++; $display("FAIL rst_sum got %0h want 0", checksum); end
    n_cmp++; if (cur_addr !== 12'h0) begin n_bad++; $display("FAIL rst_addr got %0h want 0", cur_addr); end
    n_cmp++; if (bus.in_ready_to_dev !== 1'b0) begin n_bad++; $display("FAIL rst_ready got %0h want 0", bus.in_ready_to_dev); end
    n_cmp++; if (bus.mem_write_from_io !== 1'b0) begin n_bad++; $display("FAIL rst_wr got %0h want 0", bus.mem_write_from_io); end
    n_cmp++; if ({bus.addr_to_sel, bus.write_sign_to_ac, bus.write_data_to_au} !== 43'h0) begin
      n_bad++; $display("FAIL rst_membus got %0h want 0", {bus.addr_to_sel, bus.write_sign_to_ac, bus.write_data_to_au});
    end
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_nominal;
    int b, d;
    bit seen;
    b = wr_n; d = done_n;
    set_words(31'h0000_0005, 31'h4000_0001, 31'h0000_0010, 31'h0);
    dev_on = 1'b1; dev_gap = 1'b0; mem_on = 1'b1;
    pulse_start(12'o0100, 12'd3);
    wait_done(60, seen);
    n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL nom_done got %0d want 1", seen); end
    n_cmp++; if (wr_n - b !== 3) begin n_bad++; $display("FAIL nom_nwr got %0d want 3", wr_n - b); end
    n_cmp++; if (wr_addr[idx(b)] !== 12'o0100) begin n_bad++; $display("FAIL nom_a0 got %0o want 100", wr_addr[idx(b)]); end
    n_cmp++; if (wr_addr[idx(b+1)] !== 12'o0101) begin n_bad++; $display("FAIL nom_a1 got %0o want 101", wr_addr[idx(b+1)]); end
    n_cmp++; if (wr_addr[idx(b+2)] !== 12'o0102) begin n_bad++; $display("FAIL nom_a2 got %0o want 102", wr_addr[idx(b+2)]); end
    n_cmp++; if (wr_cyc[idx(b+1)] - wr_cyc[idx(b)] !== 4) begin n_bad++; $display("FAIL nom_gap1 got %0d want 4", wr_cyc[idx(b+1)] - wr_cyc[idx(b)]); end
    n_cmp++; if (wr_cyc[idx(b+2)] - wr_cyc[idx(b+1)] !== 4) begin n_bad++; $display("FAIL nom_gap2 got %0d want 4", wr_cyc[idx(b+2)] - wr_cyc[idx(b+1)]); end
    n_cmp++; if ({wr_sign[idx(b+1)], wr_data[idx(b+1)]} !== 31'h4000_0001) begin
      n_bad++; $display("FAIL nom_word1 got %0h want 40000001", {wr_sign[idx(b+1)], wr_data[idx(b+1)]});
    end
    n_cmp++; if (checksum !== 31'h4000_0016) begin n_bad++; $display("FAIL nom_sum got %0h want 40000016", checksum); end
    n_cmp++; if (cur_addr !== 12'o0103) begin n_bad++; $display("FAIL nom_cur got %0o want 103", cur_addr); end
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL nom_idle got %0h want 0", busy); end
    n_cmp++; if (done_n - d !== 1) begin n_bad++; $display("FAIL nom_ndone got %0d want 1", done_n - d); end
    dev_on = 1'b0;
  endtask

  task automatic test_wrap;
    int b;
    bit seen;
    b = wr_n;
    set_words(31'h1, 31'h2, 31'h0, 31'h0);
    dev_on = 1'b1;
    pulse_start(12'o7776, 12'd2);
    wait_done(40, seen);
    n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL wrap_done got %0d want 1", seen); end
    n_cmp++; if (wr_addr[idx(b)] !== 12'o7776) begin n_bad++; $display("FAIL wrap_a0 got %0o want 7776", wr_addr[idx(b)]); end
    n_cmp++; if (wr_addr[idx(b+1)] !== 12'o7777) begin n_bad++; $display("FAIL wrap_a1 got %0o want 7777", wr_addr[idx(b+1)]); end
    n_cmp++; if (cur_addr !== 12'o0000) begin n_bad++; $display("FAIL wrap_cur got %0o want 0", cur_addr); end
    n_cmp++; if (checksum !== 31'h3) begin n_bad++; $display("FAIL wrap_sum got %0h want 3", checksum); end
    dev_on = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_zero_count;
    int b;
    bit seen;
    b = wr_n;
    set_words(31'h1, 31'h1, 31'h1, 31'h1);
    dev_on = 1'b1;
    pulse_start(12'o0000, 12'd0);
    wait_done(20000, seen);
    n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL zero_done got %0d want 1", seen); end
    n_cmp++; if (wr_n - b !== 4096) begin n_bad++; $display("FAIL zero_nwr got %0d want 4096", wr_n - b); end
    n_cmp++; if (checksum !== 31'h1000) begin n_bad++; $display("FAIL zero_sum got %0h want 1000", checksum); end
    n_cmp++; if (cur_addr !== 12'o0000) begin n_bad++; $display("FAIL zero_cur got %0o want 0", cur_addr); end
    dev_on = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    int b, a;
    bit seen;
    b = wr_n; a = acc_n;
    set_words(31'h3, 31'h7fff_ffff, 31'h2, 31'h0);
    dev_on = 1'b1; dev_gap = 1'b1;
    pulse_start(12'o0010, 12'd3);
    wait_done(100, seen);
    n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL bp_done got %0d want 1", seen); end
    n_cmp++; if (acc_n - a !== 3) begin n_bad++; $display("FAIL bp_nacc got %0d want 3", acc_n - a); end
    n_cmp++; if (wr_n - b !== 3) begin n_bad++; $display("FAIL bp_nwr got %0d want 3", wr_n - b); end
    n_cmp++; if (wr_cyc[idx(b+1)] - wr_cyc[idx(b)] !== 7) begin n_bad++; $display("FAIL bp_gap1 got %0d want 7", wr_cyc[idx(b+1)] - wr_cyc[idx(b)]); end
    n_cmp++; if (wr_cyc[idx(b+2)] - wr_cyc[idx(b+1)] !== 7) begin n_bad++; $display("FAIL bp_gap2 got %0d want 7", wr_cyc[idx(b+2)] - wr_cyc[idx(b+1)]); end
    n_cmp++; if (checksum !== 31'h4) begin n_bad++; $display("FAIL bp_sum got %0h want 4", checksum); end
    n_cmp++; if (cur_addr !== 12'o0013) begin n_bad++; $display("FAIL bp_cur got %0o want 13", cur_addr); end
    dev_on = 1'b0; dev_gap = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_timeout;
    int b, d, k;
    bit seen;
    b = wr_n; d = done_n;
    set_words(31'h9, 31'h0, 31'h0, 31'h0);
    dev_on = 1'b1; mem_on = 1'b0;
    pulse_start(12'o0300, 12'd1);
    wait_write(b, seen);
    n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL to_req got %0d want 1", seen); end
    dev_on = 1'b0;
    k = 0;
    while (busy && k < 40) begin @(negedge clk); k++; end
    n_cmp++; if (cyc - wr_cyc[idx(b)] !== 15) begin n_bad++; $display("FAIL to_lat got %0d want 15", cyc - wr_cyc[idx(b)]); end
    n_cmp++; if (error !== 1'b1) begin n_bad++; $display("FAIL to_err got %0h want 1", error); end
    n_cmp++; if (checksum !== 31'h0) begin n_bad++; $display("FAIL to_sum got %0h want 0", checksum); end
    n_cmp++; if (cur_addr !== 12'o0300) begin n_bad++; $display("FAIL to_cur got %0o want 300", cur_addr); end
    n_cmp++; if (done_n !== d) begin n_bad++; $display("FAIL to_done got %0d want %0d", done_n, d); end
    mem_on = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_abort_wait_word;
    int b, d;
    b = wr_n; d = done_n;
    pulse_start(12'o0400, 12'd2);
    n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL clr_err got %0h want 0", error); end
    n_cmp++; if (bus.in_ready_to_dev !== 1'b1) begin n_bad++; $display("FAIL ab_rdy1 got %0h want 1", bus.in_ready_to_dev); end
    abort = 1'b1;
    #1;
    n_cmp++; if (bus.in_ready_to_dev !== 1'b0) begin n_bad++; $display("FAIL ab_rdy0 got %0h want 0", bus.in_ready_to_dev); end
    @(negedge clk);
    abort = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL ab_idle got %0h want 0", busy); end
    @(negedge clk);
    n_cmp++; if (wr_n !== b) begin n_bad++; $display("FAIL ab_nwr got %0d want %0d", wr_n, b); end
    n_cmp++; if (done_n !== d) begin n_bad++; $display("FAIL ab_done got %0d want %0d", done_n, d); end
  endtask

  task automatic test_abort_wait_reply;
    int b, d;
    bit seen;
    b = wr_n; d = done_n;
    set_words(31'h21, 31'h22, 31'h23, 31'h0);
    dev_on = 1'b1;
    pulse_start(12'o0200, 12'd3);
    wait_write(b, seen);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    repeat (10) @(negedge clk);
    n_cmp++; if (wr_n - b !== 1) begin n_bad++; $display("FAIL abr_nwr got %0d want 1", wr_n - b); end
    n_cmp++; if (checksum !== 31'h21) begin n_bad++; $display("FAIL abr_sum got %0h want 21", checksum); end
    n_cmp++; if (cur_addr !== 12'o0201) begin n_bad++; $display("FAIL abr_cur got %0o want 201", cur_addr); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abr_idle got %0h want 0", busy); end
    n_cmp++; if (done_n !== d) begin n_bad++; $display("FAIL abr_done got %0d want %0d", done_n, d); end
    dev_on = 1'b0;
  endtask

  task automatic test_reset_midway;
    int b;
    bit seen;
    b = wr_n;
    set_words(31'h55, 31'h66, 31'h0, 31'h0);
    dev_on = 1'b1;
    pulse_start(12'o0500, 12'd2);
    wait_write(b, seen);
    resetn = 1'b0;
    dev_on = 1'b0;
    #1;
    n_cmp++; if ({busy, error, checksum, cur_addr} !== 45'h0) begin n_bad++; $display("FAIL mrst_pnl got %0h want 0", {busy, error, checksum, cur_addr}); end
    n_cmp++; if ({bus.addr_to_sel, bus.write_sign_to_ac, bus.write_data_to_au} !== 43'h0) begin
      n_bad++; $display("FAIL mrst_membus got %0h want 0", {bus.addr_to_sel, bus.write_sign_to_ac, bus.write_data_to_au});
    end
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    stray = 1'b1;
    @(negedge clk);
    stray = 1'b0;
    @(negedge clk);
    n_cmp++; if ({busy, checksum, cur_addr} !== 44'h0) begin n_bad++; $display("FAIL stray_state got %0h want 0", {busy, checksum, cur_addr}); end
    n_cmp++; if (wr_n - b !== 1) begin n_bad++; $display("FAIL stray_nwr got %0d want 1", wr_n - b); end
  endtask

  task automatic test_ignored_starts;
    int b;
    bit seen;
    b = wr_n;
    pulse_start(12'o0600, 12'd1);
    pulse_start(12'o0700, 12'd5);
    set_words(31'h11, 31'h0, 31'h0, 31'h0);
    dev_on = 1'b1;
    wait_done(40, seen);
    dev_on = 1'b0;
    n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL busy_start_done got %0d want 1", seen); end
    n_cmp++; if (wr_addr[idx(b)] !== 12'o0600) begin n_bad++; $display("FAIL busy_start_addr got %0o want 600", wr_addr[idx(b)]); end
    n_cmp++; if (cur_addr !== 12'o0601) begin n_bad++; $display("FAIL busy_start_cur got %0o want 601", cur_addr); end
    @(negedge clk);
    start_addr = 12'o0040; word_count = 12'd1;
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL sa_busy got %0h want 0", busy); end
    n_cmp++; if (cur_addr !== 12'o0601) begin n_bad++; $display("FAIL sa_cur got %0o want 601", cur_addr); end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) dev_words[i] = '0;
    test_reset;
    test_nominal;
    test_wrap;
    test_zero_count;
    test_backpressure;
    test_timeout;
    test_abort_wait_word;
    test_abort_wait_reply;
    test_reset_midway;
    test_ignored_starts;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/io_loader.md
Name: io_loader

Overview:
- Input-device load sequencer that sits directly upstream of the memory.
- Accepts 31-bit words from the input device over a valid/ready handshake and drives the memory write request/reply protocol.
- Writes each word at an auto-incrementing 12-bit address.
- Reports progress, a running checksum and completion or error to the panel.

Parameters:
- REPLY_TIMEOUT, 15: cycles allowed in WAIT_REPLY before the write is declared failed (nominal reply arrives 2 cycles after request).
- TIMER_W, 4: width of reply timer; must hold REPLY_TIMEOUT.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- start_from_pnl  in  1  one-cycle start pulse
- abort_from_pnl  in  1  abort request (level or pulse)
- start_addr_from_pnl  in  12  first memory address
- word_count_from_pnl  in  12  words to load; 0 means 4096
- in_valid_from_dev  in  1  device word valid
- in_word_from_dev  in  31  device word; bit 30 = sign, 29:0 = data
- in_ready_to_dev  out  1  loader accepts word this cycle
- mem_write_from_io  out  1  one-cycle memory write request
- mem_write_reply_to_io  in  1  memory write-complete pulse
- addr_to_sel  out  12  write address, routed to the memory address input
- write_sign_to_ac  out  1  word sign, routed to the memory write sign
- write_data_to_au  out  30  word data, routed to the memory write data
- io_busy_to_pnl  out  1  sequence in progress
- io_done_to_pnl  out  1  one-cycle pulse on successful completion
- io_error_to_pnl  out  1  timeout flag, sticky until next accepted start
- checksum_to_pnl  out  31  running sum of written words
- cur_addr_to_pnl  out  12  next address to be written

Behaviour:
- Reset (async, resetn=0): state IDLE, all outputs 0; addr_r, data_r, checksum, remaining count and timer all 0.
- Clock and reset: all flops clk posedge, async clear on resetn low; release is synchronous to clk.
- States: IDLE, WAIT_WORD, REQ, WAIT_REPLY, DONE.
- IDLE
  - busy=0, ready=0.
  - start_from_pnl=1 and abort=0: addr_r<=start_addr, remaining<=word_count (13-bit; 0 loads 4096), checksum<=0, error<=0, go to WAIT_WORD.
  - start together with abort: start is ignored.
  - Stray replies are ignored.
- WAIT_WORD
  - in_ready_to_dev=1.
  - abort=1: ready forced 0, go to IDLE; no done pulse, error unchanged.
  - Otherwise valid&ready: data_r<=in_word, go to REQ.
- REQ
  - mem_write_from_io=1 for exactly one cycle; timer<=0; go to WAIT_REPLY.
- WAIT_REPLY
  - addr_to_sel, write_sign_to_ac and write_data_to_au are held constant from REQ through the reply cycle; the memory samples them during this window.
  - On reply:
    - checksum <= (checksum + data_r) mod 2^31.
    - addr_r <= addr_r + 1, wrapping 12'o7777 -> 12'o0000.
    - remaining <= remaining - 1.
    - If remaining was 1, or an abort is pending, go to DONE / IDLE respectively; otherwise go to WAIT_WORD.
  - abort seen in REQ or WAIT_REPLY is latched as pending and takes effect only after the reply, so no write is ever torn.
  - If timer reaches REPLY_TIMEOUT before a reply: error<=1, go to IDLE. Address, checksum and remaining are not updated.
- DONE: io_done_to_pnl=1 for one cycle, then go to IDLE.
- Outputs by state:
  - io_busy_to_pnl=1 in WAIT_WORD, REQ and WAIT_REPLY.
  - cur_addr_to_pnl=addr_r and checksum_to_pnl=checksum in all states.
  - In IDLE, addr_to_sel, write_sign_to_ac and write_data_to_au hold their last values.
- start_from_pnl while busy is ignored.
- Throughput: 4 cycles per word with a nominal memory and an always-valid device: accept (T), REQ (T+1), memory writing (T+2), reply (T+3), ready again at T+4.
- Reset mid-operation clears everything immediately. The memory may still complete the in-flight write; its reply is ignored in IDLE.

Decomposition:
- Shared package: state enum, ADDR_W=12, WORD_W=31, DATA_W=30, default REPLY_TIMEOUT.
- One natural sub-module: io_reply_timer (clear/enable counter with expiry flag, parameterised by TIMER_W and REPLY_TIMEOUT).
- The address counter, remaining counter and checksum stay inline.

Test Plan:
- Nominal load: start_addr=12'o0100, count=3, device words 31'h0000_0005, 31'h4000_0001, 31'h0000_0010 always valid, memory model replies 2 cycles after request.
  - Expect writes at 0100, 0101, 0102 exactly 4 cycles apart.
  - Expect done pulse, checksum=31'h4000_0016, cur_addr=12'o0103.
- Wrap and zero count: start_addr=12'o7776, count=2 -> writes at 7776 then 7777; cur_addr=12'o0000.
  - Separately count=0 -> exactly 4096 requests issued before done.
- Backpressure and timeout: the device asserts valid only every 7th cycle -> one request per accepted word, with no request while waiting.
  - Then the memory never replies -> error=1 and IDLE exactly REPLY_TIMEOUT cycles after the request; the next start clears error.
- Abort timing:
  - Abort in WAIT_WORD -> IDLE next cycle, no request, no done.
  - Abort during WAIT_REPLY -> the reply is still consumed, checksum and address updated, then IDLE with no further request and no done.
- Reset and stray events: resetn low during WAIT_REPLY -> all outputs 0 immediately.
  - A stray reply after release changes nothing.
  - start while busy and start+abort in IDLE are both ignored.
